ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader.sv | 111 +++++++++++
 tb/tb_ram_stream_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: issues strided burst reads into a one-cycle-latency RAM and
// replays the returned words as a valid/ready stream through a 3-entry FIFO.
module ram_stream_reader #(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BDADDR-1:0] base_addr,
  input  logic [BDADDR-1:0] stride,
  input  logic [BDADDR:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [BDADDR-1:0] rd_addr,
  input  logic [BDWORD-1:0] rd_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BDWORD-1:0] out_word
);

  localparam logic [BDADDR:0] CNT_ONE = {{BDADDR{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [BDADDR:0]   remaining;
  logic [BDADDR-1:0] stride_q;
  logic              inflight;
  logic [1:0]        occ;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [BDWORD-1:0] fifo_mem [3];

  logic       push, pop;
  logic       launch, zero_start, last_issue, drain_done;
  logic [2:0] credits_used;

  assign push         = inflight;
  assign out_valid    = (occ != 2'd0);
  assign pop          = out_valid && out_ready;
  assign out_word     = fifo_mem[rd_ptr];
  assign credits_used = {1'b0, occ} + {2'b00, inflight};

  assign launch     = (state == S_IDLE) && start && (count != '0);
  assign zero_start = (state == S_IDLE) && start && (count == '0);
  assign last_issue = rd_en && (remaining == CNT_ONE);
  // Finish on the edge that empties the pipe so done lands the cycle after the final pop.
  assign drain_done = (state == S_DRAIN) && !inflight &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch)     state_nx = S_RUN;
      S_RUN:   if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  // Credit check uses only registered state, never out_ready.
  always_comb begin
    busy  = (state != S_IDLE);
    rd_en = (state == S_RUN) && (remaining != '0) && (credits_used < 3'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      stride_q  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= zero_start || drain_done;
      inflight <= rd_en;
      if (launch) begin
        rd_addr   <= base_addr;
        stride_q  <= stride;
        remaining <= count;
      end else if (rd_en) begin
        rd_addr   <= rd_addr + stride_q;
        remaining <= remaining - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      if (pop)  rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      if (push && !pop)      occ <= occ + 2'd1;
      else if (!push && pop) occ <= occ - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_word;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: small RAM model plus an arithmetic reference of the
// expected address/word sequence and cycle timing.
`timescale 1ns/1ps
module tb_ram_stream_reader;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_addr, stride;
  logic [AW:0]   count;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_word;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_word;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] got_q [$];
  logic [AW-1:0] addr_q [$];
  int first_rd, last_rd, first_pop, last_pop, done_cyc, done_n;
  int busy_c1, busy_at_done, busy_cycles, credit_viol, stab_viol;
  logic [AW+3:0] rst_obs;

  always #5 clk = ~clk;

  ram_stream_reader #(.BDADDR(AW), .BDWORD(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .count(count), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_word(rd_word), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word)
  );

  // RAM: data valid only the cycle after a read, X otherwise.
  always @(posedge clk) rd_word <= rd_en ? mem[rd_addr] : 'x;

  function automatic logic [AW-1:0] exp_addr(input int b, input int s, input int i);
    return AW'((b + i * s) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] exp_word(input int b, input int s, input int i);
    return mem[(b + i * s) % DEPTH];
  endfunction

  // Launches one burst and records what the DUT does, cycle 0 = start sample cycle.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW:0] n,
                           input int rmode, input int spur, input int rst_at);
    int issued, popped;
    logic stall;
    logic [DW-1:0] held;
    got_q.delete(); addr_q.delete();
    first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1; done_cyc = -1; done_n = 0;
    busy_c1 = 0; busy_at_done = 0; busy_cycles = 0; credit_viol = 0; stab_viol = 0;
    rst_obs = '1;
    issued = 0; popped = 0; stall = 1'b0; held = '0;
    @(negedge clk);
    base_addr = b; stride = s; count = n; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == spur);
      if (rst_at >= 0 && popped == rst_at) begin
        out_ready = 1'b0;
        rst = 1'b1;
        #1 rst_obs = {busy, done, rd_en, out_valid, rd_addr};
        #1 rst = 1'b0;
        break;
      end
      out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (busy) busy_cycles++;
      if (c == 1) busy_c1 = int'(busy);
      if (rd_en) begin
        if (issued - popped >= 3) credit_viol++;
        addr_q.push_back(rd_addr);
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        issued++;
      end
      if (stall && (!out_valid || out_word !== held)) stab_viol++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_word);
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        popped++;
      end
      stall = out_valid && !out_ready;
      held = out_word;
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(busy); end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, rd_en, out_valid} !== 4'b0000 || rd_addr !== '0) begin
      bad++;
      $display("FAIL reset_in: busy/done/rd_en/out_valid=%b rd_addr=%h want 0000/0",
               {busy, done, rd_en, out_valid}, rd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, rd_en, out_valid} !== 4'b0000 || rd_addr !== '0) begin
      bad++;
      $display("FAIL reset_out: busy/done/rd_en/out_valid=%b rd_addr=%h want 0000/0",
               {busy, done, rd_en, out_valid}, rd_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    run_burst(4'd4, 4'd1, 5'd8, 0, 4, -1);
    total++;
    if (got_q.size() != 8) begin
      bad++; $display("FAIL b2b_count: got %0d words want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got_q[i] !== DW'(4 + i)) begin
          bad++; $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], 4 + i);
        end
      end
    end
    total++;
    if (first_rd != 1 || last_rd != 8 || addr_q.size() != 8) begin
      bad++; $display("FAIL b2b_rd_window: cycles %0d..%0d n=%0d want 1..8 n=8", first_rd, last_rd, addr_q.size());
    end
    total++;
    if (first_pop != 3 || last_pop != 10) begin
      bad++; $display("FAIL b2b_valid_window: cycles %0d..%0d want 3..10", first_pop, last_pop);
    end
    total++;
    if (done_cyc != 11 || done_n != 1) begin
      bad++; $display("FAIL b2b_done: cycle %0d count %0d want 11 and 1", done_cyc, done_n);
    end
    total++;
    if (busy_c1 != 1 || busy_at_done != 0 || busy_cycles != 10) begin
      bad++; $display("FAIL b2b_busy: c1=%0d at_done=%0d cycles=%0d want 1 0 10", busy_c1, busy_at_done, busy_cycles);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_burst(4'd14, 4'd3, 5'd4, 0, -1, -1);
    total++;
    if (addr_q.size() != 4 || got_q.size() != 4) begin
      bad++; $display("FAIL wrap_count: addrs %0d words %0d want 4 4", addr_q.size(), got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr_q[i] !== exp_addr(14, 3, i) || got_q[i] !== exp_word(14, 3, i)) begin
          bad++;
          $display("FAIL wrap[%0d]: addr %0d word %h want %0d %h", i, addr_q[i], got_q[i],
                   exp_addr(14, 3, i), exp_word(14, 3, i));
        end
      end
    end
  endtask

  task automatic test_stride_zero();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_burst(4'd5, 4'd0, 5'd3, 0, -1, -1);
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL stride0_count: got %0d words want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_q[i] !== mem[5]) begin
          bad++; $display("FAIL stride0[%0d]: got %h want %h", i, got_q[i], mem[5]);
        end
      end
    end
    total++;
    if (done_cyc != 6 || done_n != 1) begin
      bad++; $display("FAIL stride0_done: cycle %0d count %0d want 6 1", done_cyc, done_n);
    end
  endtask

  task automatic test_count_zero();
    run_burst(AW'($urandom), AW'($urandom), 5'd0, 0, -1, -1);
    total++;
    if (done_cyc != 1 || done_n != 1) begin
      bad++; $display("FAIL zero_done: cycle %0d count %0d want 1 1", done_cyc, done_n);
    end
    total++;
    if (addr_q.size() != 0 || busy_cycles != 0) begin
      bad++; $display("FAIL zero_idle: reads %0d busy cycles %0d want 0 0", addr_q.size(), busy_cycles);
    end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 4; it++) begin
      int b, s;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      b = $urandom_range(0, DEPTH - 1);
      s = $urandom_range(0, DEPTH - 1);
      run_burst(AW'(b), AW'(s), 5'd10, 1, -1, -1);
      total++;
      if (got_q.size() != 10) begin
        bad++; $display("FAIL bp%0d_count: got %0d words want 10", it, got_q.size());
      end else begin
        for (int i = 0; i < 10; i++) begin
          total++;
          if (got_q[i] !== exp_word(b, s, i)) begin
            bad++; $display("FAIL bp%0d_word[%0d]: got %h want %h", it, i, got_q[i], exp_word(b, s, i));
          end
        end
      end
      total++;
      if (stab_viol != 0 || credit_viol != 0) begin
        bad++; $display("FAIL bp%0d_rules: unstable %0d over-credit %0d want 0 0", it, stab_viol, credit_viol);
      end
      total++;
      if (done_n != 1 || done_cyc != last_pop + 1) begin
        bad++; $display("FAIL bp%0d_done: count %0d cycle %0d want 1 at %0d", it, done_n, done_cyc, last_pop + 1);
      end
    end
  endtask

  task automatic test_full();
    int b, s;
    int seen [DEPTH];
    int wrong;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; seen[i] = 0; end
    b = $urandom_range(0, DEPTH - 1);
    s = 2 * $urandom_range(0, 7) + 1;
    run_burst(AW'(b), AW'(s), 5'd16, 0, -1, -1);
    wrong = 0;
    foreach (addr_q[i]) seen[addr_q[i]]++;
    for (int i = 0; i < DEPTH; i++) if (seen[i] != 1) wrong++;
    total++;
    if (addr_q.size() != DEPTH || wrong != 0) begin
      bad++; $display("FAIL full_cover: reads %0d bad addrs %0d want 16 0", addr_q.size(), wrong);
    end
    wrong = 0;
    if (got_q.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) if (got_q[i] !== exp_word(b, s, i)) wrong++;
    end else wrong = -1;
    total++;
    if (wrong != 0) begin
      bad++; $display("FAIL full_words: words %0d wrong %0d want 16 0", got_q.size(), wrong);
    end
    total++;
    if (done_cyc != 19 || done_n != 1) begin
      bad++; $display("FAIL full_done: cycle %0d count %0d want 19 1", done_cyc, done_n);
    end
  endtask

  task automatic test_reset_mid();
    int late_done, late_valid;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_burst(AW'($urandom), 4'd1, 5'd16, 0, -1, 5);
    total++;
    if (rst_obs !== '0) begin
      bad++; $display("FAIL midrst_outputs: busy/done/rd_en/valid/addr=%b want 0", rst_obs);
    end
    late_done = 0; late_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) late_done++;
      if (out_valid || busy) late_valid++;
    end
    total++;
    if (late_done != 0 || late_valid != 0) begin
      bad++; $display("FAIL midrst_quiet: done %0d valid/busy %0d want 0 0", late_done, late_valid);
    end
    run_burst(4'd0, 4'd1, 5'd2, 0, -1, -1);
    total++;
    if (got_q.size() != 2 || got_q[0] !== mem[0] || got_q[1] !== mem[1]) begin
      bad++; $display("FAIL midrst_next: %0d words first %h want 2 words %h %h", got_q.size(),
                      (got_q.size() > 0) ? got_q[0] : '0, mem[0], mem[1]);
    end
    total++;
    if (done_n != 1 || done_cyc != 5) begin
      bad++; $display("FAIL midrst_next_done: count %0d cycle %0d want 1 5", done_n, done_cyc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_stride_zero();
    test_count_zero();
    test_backpressure();
    test_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
